// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder: word width, FSM state type
// and address/word-index width helpers.
package mips_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   function automatic int index_width(input int depth_words);
      return $clog2(depth_words);
   endfunction

   function automatic int addr_width(input int depth_words);
      return $clog2(depth_words) + 2;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with synchronous byte-enabled write and combinational read.
// Contents are never reset.
module dmem_array
   import mips_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int IW = index_width(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [IW-1:0]     index,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed wait states in front of a
// word array. Define DMEM_BYTE_ENABLE_EN to add the req_be store byte enables.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting down wait states; access happens when the count is 0
// RESP  | response held until resp_ready
module dmem_responder
   import mips_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_ENABLE_EN
   input  logic [3:0]        req_be,
`endif
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int IW = index_width(DEPTH_WORDS);

   dmem_state_t       state;
   logic [3:0]        cnt;
   logic              write_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;

   logic              accept;
   logic              acc_write;
   logic [WORD_W-1:0] acc_addr;
   logic [WORD_W-1:0] acc_wdata;
   logic [3:0]        acc_be;
   logic [29:0]       acc_idx;
   logic              acc_err;
   logic              do_access;
   logic              mem_we;
   logic [WORD_W-1:0] mem_rdata;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   // With zero wait states the access happens on the accept edge, so it must
   // see the live request rather than the capture registers.
   always_comb begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state == IDLE) begin
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
      end
   end

`ifdef DMEM_BYTE_ENABLE_EN
   logic [3:0] be_q;
   assign acc_be = (state == IDLE) ? req_be : be_q;
`else
   assign acc_be = 4'hF;
`endif

   assign acc_idx   = acc_addr[31:2];
   assign acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_idx} >= 32'(DEPTH_WORDS));
   assign do_access = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd0));
   assign mem_we    = do_access && acc_write && !acc_err;

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .we    (mem_we),
      .be    (acc_be),
      .index (acc_idx[IW-1:0]),
      .wdata (acc_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
`ifdef DMEM_BYTE_ENABLE_EN
         be_q       <= '0;
`endif
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (do_access) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_write || acc_err) ? '0 : mem_rdata;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  write_q <= req_write;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
`ifdef DMEM_BYTE_ENABLE_EN
                  be_q    <= req_be;
`endif
                  if (WAIT_CYCLES != 0) begin
                     cnt   <= 4'(WAIT_CYCLES - 1);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) driven by
// directed transactions and checked every cycle against a behavioural model.
module tb_dmem_responder;

   localparam int W0 = 2;
   localparam int D0 = 256;
   localparam int W1 = 0;
   localparam int D1 = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
`ifdef DMEM_BYTE_ENABLE_EN
   logic [3:0]  req_be     [2];
`endif
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   dmem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(W0)) u_dut0 (
      .clk        (clk),
      .rst        (rst[0]),
      .req_valid  (req_valid[0]),
      .req_ready  (req_ready[0]),
      .req_write  (req_write[0]),
      .req_addr   (req_addr[0]),
      .req_wdata  (req_wdata[0]),
`ifdef DMEM_BYTE_ENABLE_EN
      .req_be     (req_be[0]),
`endif
      .resp_valid (resp_valid[0]),
      .resp_ready (resp_ready[0]),
      .resp_rdata (resp_rdata[0]),
      .resp_err   (resp_err[0])
   );

   dmem_responder #(.DEPTH_WORDS(D1), .WAIT_CYCLES(W1)) u_dut1 (
      .clk        (clk),
      .rst        (rst[1]),
      .req_valid  (req_valid[1]),
      .req_ready  (req_ready[1]),
      .req_write  (req_write[1]),
      .req_addr   (req_addr[1]),
      .req_wdata  (req_wdata[1]),
`ifdef DMEM_BYTE_ENABLE_EN
      .req_be     (req_be[1]),
`endif
      .resp_valid (resp_valid[1]),
      .resp_ready (resp_ready[1]),
      .resp_rdata (resp_rdata[1]),
      .resp_err   (resp_err[1])
   );

   int total;
   int bad;
   int cyc;

   // model state
   bit          pend       [2];
   int          acc_cyc    [2];
   int          first_seen [2];
   logic [31:0] exp_rd     [2];
   logic        exp_er     [2];
   logic [31:0] mdl        [int];

   function automatic int wc(input int d);
      return (d == 0) ? W0 : W1;
   endfunction

   function automatic int dep(input int d);
      return (d == 0) ? D0 : D1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin : cmp
      bit ev;
      for (int d = 0; d < 2; d++) begin
         ev = pend[d] && (cyc >= acc_cyc[d] + wc(d));
         chk($sformatf("req_ready%0d", d), {31'b0, req_ready[d]}, {31'b0, !pend[d] && !rst[d]});
         chk($sformatf("resp_valid%0d", d), {31'b0, resp_valid[d]}, {31'b0, ev});
         if (ev) begin
            chk($sformatf("resp_rdata%0d", d), resp_rdata[d], exp_rd[d]);
            chk($sformatf("resp_err%0d", d), {31'b0, resp_err[d]}, {31'b0, exp_er[d]});
            if (first_seen[d] < 0 && resp_valid[d]) first_seen[d] = cyc;
         end else if (rst[d]) begin
            chk($sformatf("rst_rdata%0d", d), resp_rdata[d], 32'h0);
            chk($sformatf("rst_err%0d", d), {31'b0, resp_err[d]}, 32'h0);
         end
      end
   end

   // Entered and left at 1 time unit after a rising edge.
   task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input int stall,
                      input bit rst_mid, output logic [31:0] got_rd, output logic got_er);
      int idx;
      int key;
      bit er;
      logic [31:0] nv;
      logic [3:0]  ebe;
      got_rd = '0;
      got_er = 1'b0;
`ifdef DMEM_BYTE_ENABLE_EN
      ebe = be;
      req_be[d] = be;
`else
      ebe = 4'hF;
`endif
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      @(posedge clk); #1;
      acc_cyc[d]    = cyc;
      first_seen[d] = -1;
      idx = int'(addr >> 2);
      er  = (addr[1:0] != 2'b00) || (idx >= dep(d));
      key = er ? -1 : d * (1 << 20) + idx;
      exp_er[d] = er;
      nv = (!er && mdl.exists(key)) ? mdl[key] : 32'hx;
      exp_rd[d] = (wr || er) ? 32'h0 : nv;
      for (int b = 0; b < 4; b++) if (ebe[b]) nv[8*b +: 8] = wd[8*b +: 8];
      pend[d] = 1'b1;
      // junk on the request side while busy; the responder must ignore it
      req_write[d] = !wr;
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      if (rst_mid) begin
         #2;
         rst[d]  = 1'b1;
         pend[d] = 1'b0;
         #1;
         chk("rstmid_valid", {31'b0, resp_valid[d]}, 32'h0);
         chk("rstmid_ready", {31'b0, req_ready[d]}, 32'h0);
         chk("rstmid_rdata", resp_rdata[d], 32'h0);
         chk("rstmid_err", {31'b0, resp_err[d]}, 32'h0);
         @(posedge clk); #1;
         req_valid[d] = 1'b0;
         rst[d] = 1'b0;
         return;
      end
      while (cyc < acc_cyc[d] + wc(d)) begin
         @(posedge clk); #1;
      end
      repeat (stall) begin
         @(posedge clk); #1;
      end
      got_rd = resp_rdata[d];
      got_er = resp_err[d];
      resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      if (wr && !er) mdl[key] = nv;
      pend[d] = 1'b0;
      req_valid[d] = 1'b0;
      if (d == 0) resp_ready[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          a1;
      int          a2;
      total = 0;
      bad = 0;
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         req_valid[d] = 1'b0;
         req_write[d] = 1'b0;
         req_addr[d] = '0;
         req_wdata[d] = '0;
`ifdef DMEM_BYTE_ENABLE_EN
         req_be[d] = 4'h0;
`endif
         pend[d] = 1'b0;
         acc_cyc[d] = 0;
         first_seen[d] = -1;
         exp_rd[d] = '0;
         exp_er[d] = 1'b0;
      end
      resp_ready[0] = 1'b0;
      resp_ready[1] = 1'b1;
      #3;
      for (int d = 0; d < 2; d++) begin
         chk("reset_ready", {31'b0, req_ready[d]}, 32'h0);
         chk("reset_valid", {31'b0, resp_valid[d]}, 32'h0);
         chk("reset_rdata", resp_rdata[d], 32'h0);
         chk("reset_err", {31'b0, resp_err[d]}, 32'h0);
      end
      @(posedge clk); #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      #1;
      chk("release_ready0", {31'b0, req_ready[0]}, 32'h1);
      @(posedge clk); #1;

      // 2 wait states
      txn(0, 1, 32'h0000_0000, 32'h0123_4567, 4'hF, 0, 0, rd, er);
      txn(0, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 0, 0, rd, er);
      txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, er);
      chk("st_rdata", rd, 32'h0);
      chk("st_err", {31'b0, er}, 32'h0);
      chk("st_latency", first_seen[0] + 1 - acc_cyc[0], 3);
      txn(0, 0, 32'h0000_0010, 32'h0, 4'hF, 0, 0, rd, er);
      chk("ld10_rdata", rd, 32'hDEAD_BEEF);
      chk("ld10_err", {31'b0, er}, 32'h0);
      chk("ld_latency", first_seen[0] + 1 - acc_cyc[0], 3);
      txn(0, 0, 32'h0000_0013, 32'h0, 4'hF, 0, 0, rd, er);
      chk("misalign_rdata", rd, 32'h0);
      chk("misalign_err", {31'b0, er}, 32'h1);
      txn(0, 1, 32'h0000_0400, 32'h9999_9999, 4'hF, 0, 0, rd, er);
      chk("oor_st_err", {31'b0, er}, 32'h1);
      txn(0, 0, 32'h0000_0000, 32'h0, 4'hF, 0, 0, rd, er);
      chk("word0_unchanged", rd, 32'h0123_4567);
      txn(0, 0, 32'h0000_0010, 32'h0, 4'hF, 5, 0, rd, er);
      chk("stall_rdata", rd, 32'hDEAD_BEEF);
      txn(0, 1, 32'h0000_0020, 32'h5555_5555, 4'hF, 0, 1, rd, er);
      txn(0, 0, 32'h0000_0020, 32'h0, 4'hF, 0, 0, rd, er);
      chk("rst_discard", rd, 32'hCAFE_F00D);
      txn(0, 1, 32'h0000_03FC, 32'h0BAD_C0DE, 4'hF, 1, 0, rd, er);
      txn(0, 0, 32'h0000_03FC, 32'h0, 4'hF, 0, 0, rd, er);
      chk("last_word", rd, 32'h0BAD_C0DE);
      chk("last_word_err", {31'b0, er}, 32'h0);
      txn(0, 0, 32'h8000_0010, 32'h0, 4'hF, 0, 0, rd, er);
      chk("high_addr_err", {31'b0, er}, 32'h1);
`ifdef DMEM_BYTE_ENABLE_EN
      txn(0, 1, 32'h0000_0030, 32'h1122_3344, 4'hF, 0, 0, rd, er);
      txn(0, 1, 32'h0000_0030, 32'hAABB_CCDD, 4'b0101, 0, 0, rd, er);
      txn(0, 0, 32'h0000_0030, 32'h0, 4'h0, 0, 0, rd, er);
      chk("be_merge", rd, 32'h11BB_33DD);
      txn(0, 1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000, 0, 0, rd, er);
      chk("be_zero_err", {31'b0, er}, 32'h0);
      txn(0, 0, 32'h0000_0030, 32'h0, 4'hF, 0, 0, rd, er);
      chk("be_zero_noop", rd, 32'h11BB_33DD);
`endif

      // 0 wait states, back-to-back with resp_ready held high
      txn(1, 1, 32'h0000_0008, 32'h1111_1111, 4'hF, 0, 0, rd, er);
      a1 = acc_cyc[1];
      chk("w0_latency", first_seen[1] + 1 - acc_cyc[1], 1);
      txn(1, 0, 32'h0000_0008, 32'h0, 4'hF, 0, 0, rd, er);
      a2 = acc_cyc[1];
      chk("w0_gap1", a2 - a1, 2);
      chk("w0_ld", rd, 32'h1111_1111);
      txn(1, 1, 32'h0000_00FC, 32'h2222_2222, 4'hF, 0, 0, rd, er);
      a1 = acc_cyc[1];
      chk("w0_gap2", a1 - a2, 2);
      txn(1, 0, 32'h0000_00FC, 32'h0, 4'hF, 0, 0, rd, er);
      chk("w0_ld_last", rd, 32'h2222_2222);
      txn(1, 0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, rd, er);
      chk("w0_oor_err", {31'b0, er}, 32'h1);
      chk("w0_oor_rdata", rd, 32'h0);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words of storage (power of two, 4..65536).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 req_valid  input  1  core presents a load/store request.
REQ-006 req_ready  output  1  responder accepts the request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core consumes the response this cycle.
REQ-012 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 IDLE: req_ready = 1; all other states: req_ready = 0.
REQ-016 Handshake: a request is accepted when req_valid and req_ready are both 1. Accept captures write, addr and wdata into internal registers.
REQ-017 On accept with WAIT_CYCLES > 0: load the wait counter with WAIT_CYCLES-1 and go to WAIT. With WAIT_CYCLES = 0: go directly to RESP.
REQ-018 WAIT: decrement the counter each cycle; at 0, perform the access and go to RESP.
REQ-019 Latency: an accept at edge T raises resp_valid after edge T+WAIT_CYCLES+1.
REQ-020 RESP: hold resp_valid, resp_rdata and resp_err stable until resp_valid and resp_ready are both 1, then return to IDLE.
REQ-021 The next request can be accepted no earlier than the cycle after the response handshake; there is no overlap.
REQ-022 Word index = addr[31:2]. Error if addr[1:0] != 0 or index >= DEPTH_WORDS.
REQ-023 Erroring store: memory is unchanged and resp_err = 1. Erroring load: resp_rdata = 0 and resp_err = 1.
REQ-024 Store performs a single write of the selected word at the end of WAIT (or on the RESP-entry edge when WAIT_CYCLES = 0); resp_rdata = 0.
REQ-025 Load returns the word contents as sampled at the access edge.
REQ-026 req_valid deasserting in WAIT or RESP has no effect. Inputs are ignored outside IDLE.

Reset
REQ-027 Reset forces IDLE, counter = 0, req_ready = 0 while reset is asserted and 1 after release, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-028 Reset asserted mid-transaction abandons it. A pending store not yet written is discarded.
REQ-029 Storage contents are not cleared by reset.

Configuration
REQ-030 Macro DMEM_BYTE_ENABLE_EN. When defined, the block adds input req_be[3:0]; a store writes only the bytes whose enable is 1; a store with req_be = 0 is a legal no-op. A load ignores req_be.
REQ-031 Without DMEM_BYTE_ENABLE_EN, the req_be port does not exist and every store writes all 4 bytes.

Structure
REQ-032 Shared package mips_pkg holds: the word width constant (32), the FSM state typedef, and the address/word-index width helpers.
REQ-033 One sub-module, dmem_array: synchronous-write, combinational-read storage with a byte-write-enable input. The top drives that input with 4'hF when the macro is absent.

Verification
REQ-034 WAIT_CYCLES=2: store 0xDEADBEEF at addr 0x10, then load 0x10 -> rdata 0xDEADBEEF, err 0; resp_valid rises 3 cycles after each accept.
REQ-035 Load addr 0x13 -> resp_err 1, rdata 0. Store to addr DEPTH_WORDS*4 -> err 1 and a reload of word 0 is unchanged.
REQ-036 resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready 0 throughout. Response handshake -> IDLE next cycle.
REQ-037 Reset asserted during WAIT of a store to 0x20 -> outputs cleared immediately; a later load of 0x20 returns its pre-store value.
REQ-038 WAIT_CYCLES=0 back-to-back with resp_ready=1: accept/response alternate every other cycle, accept to resp_valid latency 1.
REQ-039 DMEM_BYTE_ENABLE_EN: word 0x11223344, store 0xAABBCCDD with be=4'b0101 -> load returns 0x11BB33DD.
